// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bundle: fetch port, data port and memory-side bus.
// master = arbiter side, slave = requesters plus the memory model.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ready;
    logic [DW-1:0] dm_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between fetch and data ports.
// Latency: request sampled in IDLE cycle t -> ready pulse in cycle t+LAT+1.
// Backpressure: requesters hold req until their ready pulse; one access in flight, others wait in IDLE.
module mem_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus,
    output logic          busy,
    output logic          owner
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          last_owner;
    logic          grant_vld;
    logic          grant_dm;

    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          if_ready_q;
    logic          dm_ready_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] dm_rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        grant_vld = bus.if_req | bus.dm_req;
        // On a tie the port that did not win last time gets the grant.
        grant_dm  = bus.dm_req & (~bus.if_req | ~last_owner);
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            last_owner  <= 1'b0;
            owner       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner       <= grant_dm;
                        last_owner  <= grant_dm;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= grant_dm & bus.dm_we;
                        mem_addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
                        mem_wdata_q <= grant_dm ? bus.dm_wdata : '0;
                        cnt         <= 4'(LAT - 1);
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (owner) begin
                            dm_ready_q <= 1'b1;
                            // Writes leave the data-port read register untouched.
                            if (!mem_we_q) dm_rdata_q <= bus.mem_rdata;
                        end else begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=2 main instance plus LAT=1 and LAT=15 latency builds.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus15 ();
    logic busy, owner, busy1, owner1, busy15, owner15;

    mem_arbiter #(.LAT(2), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .owner(owner));
    mem_arbiter #(.LAT(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1), .owner(owner1));
    mem_arbiter #(.LAT(15), .AW(32), .DW(32)) dut15 (
        .clk(clk), .rst_n(rst_n), .bus(bus15), .busy(busy15), .owner(owner15));

    // Memory model: data is only valid in the LAT-th cycle of mem_en, garbage otherwise.
    logic [31:0] rd_value = 32'h0;
    int en_cnt = 0;
    always @(posedge clk) en_cnt <= bus.mem_en ? en_cnt + 1 : 0;
    assign bus.mem_rdata   = (bus.mem_en && en_cnt == 1) ? rd_value : 32'hBAD0BAD0;
    assign bus1.mem_rdata  = 32'h11110001;
    assign bus15.mem_rdata = 32'h15150015;

    int checks = 0;
    int errors = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        checks++;
        if ({busy, owner, bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {busy, owner, bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready}, 6'b0);
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {bus.if_rdata, bus.dm_rdata});
        end
        checks++;
        if ({busy1, busy15, owner1, owner15} !== 4'b0) begin
            errors++;
            $display("FAIL reset_lat_builds: got %b expected 0000", {busy1, busy15, owner1, owner15});
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_fetch;
        bus.if_req = 1'b1; bus.if_addr = 32'h10; rd_value = 32'h2402000A;
        step(1);
        checks++;
        if ({busy, owner, bus.mem_en, bus.mem_we, bus.if_ready} !== 5'b10100) begin
            errors++;
            $display("FAIL fetch_c1_ctrl: got %b expected 10100",
                     {busy, owner, bus.mem_en, bus.mem_we, bus.if_ready});
        end
        checks++;
        if (bus.mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL fetch_c1_addr: got %h expected 00000010", bus.mem_addr);
        end
        step(1);
        checks++;
        if ({bus.mem_en, bus.if_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_c2_ctrl: got %b expected 10", {bus.mem_en, bus.if_ready});
        end
        step(1);
        checks++;
        if ({bus.mem_en, bus.if_ready, bus.dm_ready} !== 3'b010) begin
            errors++;
            $display("FAIL fetch_c3_ready: got %b expected 010", {bus.mem_en, bus.if_ready, bus.dm_ready});
        end
        checks++;
        if (bus.if_rdata !== 32'h2402000A) begin
            errors++;
            $display("FAIL fetch_rdata: got %h expected 2402000a", bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step(1);
        checks++;
        if ({busy, bus.if_ready} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_c4_idle: got %b expected 00", {busy, bus.if_ready});
        end
    endtask

    task automatic test_dm_read;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h44; rd_value = 32'h12345678;
        step(1);
        checks++;
        if ({owner, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h44}) begin
            errors++;
            $display("FAIL dm_read_grant: got %h expected %h", {owner, bus.mem_we, bus.mem_addr}, {2'b10, 32'h44});
        end
        step(2);
        checks++;
        if ({bus.dm_ready, bus.if_ready} !== 2'b10) begin
            errors++;
            $display("FAIL dm_read_ready: got %b expected 10", {bus.dm_ready, bus.if_ready});
        end
        checks++;
        if (bus.dm_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL dm_read_rdata: got %h expected 12345678", bus.dm_rdata);
        end
        checks++;
        if (bus.if_rdata !== 32'h2402000A) begin
            errors++;
            $display("FAIL dm_read_if_rdata_kept: got %h expected 2402000a", bus.if_rdata);
        end
        bus.dm_req = 1'b0;
        step(1);
    endtask

    task automatic test_write;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40;
        bus.dm_wdata = 32'hDEADBEEF; rd_value = 32'hCAFEF00D;
        for (int c = 1; c <= 2; c++) begin
            step(1);
            checks++;
            if ({bus.mem_en, bus.mem_we, owner, bus.mem_addr, bus.mem_wdata} !==
                {3'b111, 32'h40, 32'hDEADBEEF}) begin
                errors++;
                $display("FAIL write_c%0d_bus: got %h expected %h", c,
                         {bus.mem_en, bus.mem_we, owner, bus.mem_addr, bus.mem_wdata},
                         {3'b111, 32'h40, 32'hDEADBEEF});
            end
        end
        step(1);
        checks++;
        if ({bus.dm_ready, bus.mem_we, bus.mem_en} !== 3'b100) begin
            errors++;
            $display("FAIL write_ready: got %b expected 100", {bus.dm_ready, bus.mem_we, bus.mem_en});
        end
        checks++;
        if (bus.dm_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL write_rdata_kept: got %h expected 12345678", bus.dm_rdata);
        end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        step(1);
    endtask

    task automatic test_round_robin;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h20;
        bus.dm_req = 1'b1; bus.dm_addr = 32'h60; bus.dm_we = 1'b0; rd_value = 32'h5A5A0001;
        for (int c = 1; c <= 16; c++) begin
            logic [1:0] exp_rdy;
            step(1);
            exp_rdy = {(c == 3 || c == 11), (c == 7 || c == 15)};
            checks++;
            if ({bus.dm_ready, bus.if_ready} !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready_c%0d: got %b expected %b", c, {bus.dm_ready, bus.if_ready}, exp_rdy);
            end
            if (c % 4 == 1) begin
                checks++;
                if (owner !== ((c / 4) % 2 == 0)) begin
                    errors++;
                    $display("FAIL rr_owner_c%0d: got %b expected %b", c, owner, ((c / 4) % 2 == 0));
                end
            end
            if (c == 11) begin
                checks++;
                if (bus.dm_rdata !== 32'h5A5A0001) begin
                    errors++;
                    $display("FAIL rr_dm_rdata: got %h expected 5a5a0001", bus.dm_rdata);
                end
            end
            if (c == 15) begin
                checks++;
                if (bus.if_rdata !== 32'h5A5A0001) begin
                    errors++;
                    $display("FAIL rr_if_rdata: got %h expected 5a5a0001", bus.if_rdata);
                end
                bus.if_req = 1'b0; bus.dm_req = 1'b0;
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_access;
        bus.if_req = 1'b1; bus.if_addr = 32'h30; rd_value = 32'h77770000;
        step(2);
        checks++;
        if ({busy, bus.mem_en} !== 2'b11) begin
            errors++;
            $display("FAIL rst_mid_pre: got %b expected 11", {busy, bus.mem_en});
        end
        rst_n = 1'b0; bus.if_req = 1'b0;
        step(1);
        checks++;
        if ({busy, owner, bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready,
             bus.mem_addr, bus.if_rdata, bus.dm_rdata} !== 102'h0) begin
            errors++;
            $display("FAIL rst_mid_zero: got %h expected 0",
                     {busy, owner, bus.mem_en, bus.mem_we, bus.if_ready, bus.dm_ready,
                      bus.mem_addr, bus.if_rdata, bus.dm_rdata});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1);
            checks++;
            if ({busy, bus.if_ready, bus.dm_ready} !== 3'b000) begin
                errors++;
                $display("FAIL rst_mid_no_pulse_%0d: got %b expected 000", c, {busy, bus.if_ready, bus.dm_ready});
            end
        end
        // Re-request, dropped after one cycle: the access must still complete.
        bus.if_req = 1'b1; bus.if_addr = 32'h34; rd_value = 32'h13572468;
        step(1);
        bus.if_req = 1'b0;
        step(2);
        checks++;
        if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h13572468}) begin
            errors++;
            $display("FAIL rst_mid_rerequest: got %h expected %h", {bus.if_ready, bus.if_rdata}, {1'b1, 32'h13572468});
        end
        step(1);
        checks++;
        if ({busy, bus.if_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_final_idle: got %b expected 00", {busy, bus.if_ready});
        end
    endtask

    task automatic test_ignore_during_access;
        bus.if_req = 1'b1; bus.if_addr = 32'h50; rd_value = 32'h55550050;
        bus.dm_addr = 32'h70; bus.dm_we = 1'b0;
        step(1);
        bus.dm_req = 1'b1;
        step(1);
        bus.dm_req = 1'b0;
        checks++;
        if ({owner, bus.mem_addr} !== {1'b0, 32'h50}) begin
            errors++;
            $display("FAIL ign_c2_owner: got %h expected %h", {owner, bus.mem_addr}, {1'b0, 32'h50});
        end
        step(1);
        bus.dm_req = 1'b1;
        checks++;
        if ({bus.if_ready, bus.dm_ready, bus.if_rdata} !== {2'b10, 32'h55550050}) begin
            errors++;
            $display("FAIL ign_c3_fetch_done: got %h expected %h",
                     {bus.if_ready, bus.dm_ready, bus.if_rdata}, {2'b10, 32'h55550050});
        end
        bus.if_req = 1'b0; rd_value = 32'h66660070;
        step(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_c4_idle: got %b expected 0", busy);
        end
        step(1);
        checks++;
        if ({busy, owner, bus.mem_addr} !== {2'b11, 32'h70}) begin
            errors++;
            $display("FAIL ign_c5_dm_grant: got %h expected %h", {busy, owner, bus.mem_addr}, {2'b11, 32'h70});
        end
        step(2);
        checks++;
        if ({bus.dm_ready, bus.dm_rdata} !== {1'b1, 32'h66660070}) begin
            errors++;
            $display("FAIL ign_c7_dm_done: got %h expected %h", {bus.dm_ready, bus.dm_rdata}, {1'b1, 32'h66660070});
        end
        bus.dm_req = 1'b0;
        step(1);
    endtask

    task automatic test_latency_builds;
        int n;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h8;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus1.if_ready && n < 40);
        bus1.if_req = 1'b0;
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL lat1_cycles: got %0d expected 2", n);
        end
        checks++;
        if (bus1.if_rdata !== 32'h11110001) begin
            errors++;
            $display("FAIL lat1_rdata: got %h expected 11110001", bus1.if_rdata);
        end
        step(2);
        bus15.if_req = 1'b1; bus15.if_addr = 32'hC;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus15.if_ready && n < 40);
        bus15.if_req = 1'b0;
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL lat15_cycles: got %0d expected 16", n);
        end
        checks++;
        if (bus15.if_rdata !== 32'h15150015) begin
            errors++;
            $display("FAIL lat15_rdata: got %h expected 15150015", bus15.if_rdata);
        end
        step(2);
    endtask

    initial begin
        bus.if_req = 1'b0;   bus.if_addr = '0;
        bus.dm_req = 1'b0;   bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus1.if_req = 1'b0;  bus1.if_addr = '0;
        bus1.dm_req = 1'b0;  bus1.dm_we = 1'b0; bus1.dm_addr = '0; bus1.dm_wdata = '0;
        bus15.if_req = 1'b0; bus15.if_addr = '0;
        bus15.dm_req = 1'b0; bus15.dm_we = 1'b0; bus15.dm_addr = '0; bus15.dm_wdata = '0;

        test_reset();
        test_fetch();
        test_dm_read();
        test_write();
        test_round_robin();
        test_reset_mid_access();
        test_ignore_during_access();
        test_latency_builds();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning memory read/write latency in cycles; legal range 1..15.
REQ-002 The block SHALL have parameter AW, default 32, meaning address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 if_req  in  1  instruction-fetch request; held until if_ready.
REQ-007 if_addr  in  AW  fetch address; stable while if_req high.
REQ-008 if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-009 if_rdata  out  DW  registered fetch data.
REQ-010 dm_req  in  1  data-memory request; held until dm_ready.
REQ-011 dm_we  in  1  1=write, 0=read; stable while dm_req high.
REQ-012 dm_addr  in  AW  data address; stable while dm_req high.
REQ-013 dm_wdata  in  DW  write data; stable while dm_req high.
REQ-014 dm_ready  out  1  one-cycle pulse: data access complete.
REQ-015 dm_rdata  out  DW  registered read data.
REQ-016 mem_en  out  1  shared-memory enable (registered).
REQ-017 mem_we  out  1  shared-memory write enable (registered).
REQ-018 mem_addr  out  AW  shared-memory address (registered).
REQ-019 mem_wdata  out  DW  shared-memory write data (registered).
REQ-020 mem_rdata  in  DW  shared-memory read data; valid after LAT cycles of mem_en.
REQ-021 busy  out  1  high whenever state is not IDLE.
REQ-022 owner  out  1  0=fetch port, 1=data port; the port holding the current grant.

Function
REQ-023 The FSM SHALL have states IDLE, ACCESS and RESP; IDLE->ACCESS on any sampled request, ACCESS->RESP when wait counter is 0, RESP->IDLE unconditionally.
REQ-024 Requests SHALL be sampled only in IDLE; if_req/dm_req in ACCESS or RESP are ignored.
REQ-025 Grant with only one request SHALL go to that port.
REQ-026 Grant with both requests SHALL go to the port not granted last (round-robin via 1-bit last_owner); last_owner updates on every grant.
REQ-027 On grant, the block SHALL latch address, we and wdata into mem_addr/mem_we/mem_wdata, set mem_en=1, set owner, load counter with LAT-1.
REQ-028 The fetch port SHALL always drive mem_we=0.
REQ-029 In ACCESS, mem_en/mem_we/mem_addr/mem_wdata SHALL hold; counter decrements by 1 per cycle; no wrap (exit at 0).
REQ-030 On the ACCESS->RESP edge, mem_en and mem_we SHALL clear, and for reads mem_rdata SHALL be captured into the owner's rdata register.
REQ-031 For writes, dm_rdata SHALL retain its previous value.
REQ-032 In RESP, the owner's ready SHALL be 1 for exactly one cycle; the other port's ready SHALL be 0.
REQ-033 Latency: request seen in IDLE cycle t -> ready high in cycle t+LAT+1; back-to-back accesses start no faster than every LAT+2 cycles.
REQ-034 The non-owner's rdata register SHALL never change during another port's access.
REQ-035 A request dropped before ready (protocol violation) SHALL NOT abort the access; the access completes and the pulse is issued.

Reset
REQ-036 While rst_n=0 at a rising edge: state=IDLE, counter=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0, owner=0, last_owner=0, busy=0.
REQ-037 Reset asserted mid-ACCESS or in RESP SHALL abort the access with no ready pulse; first tie after reset SHALL grant the data port.

Verification
REQ-038 LAT=2, if_req=1, if_addr=0x10, mem_rdata=0x2402000A -> mem_en high cycles 1-2, if_ready pulse in cycle 3, if_rdata=0x2402000A, busy low in cycle 4.
REQ-039 dm_req, dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF for 2 cycles, dm_ready pulse, dm_rdata unchanged.
REQ-040 Both requests held high from reset release -> grants alternate dm, if, dm, if; each ready pulse 4 cycles apart at LAT=2.
REQ-041 rst_n low during second ACCESS cycle -> next cycle all outputs zero, no ready pulse; re-request completes normally.
REQ-042 LAT=1 and LAT=15 builds, single fetch -> ready exactly LAT+1 cycles after request sampled.
REQ-043 dm_req toggled during an active fetch -> ignored; fetch completes, dm granted at next IDLE.
